// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
// Shares a single external pixel SRAM between VGA scan-out reads and queued
// GPU pixel writes. Scan reads always win the SRAM cycle; GPU writes wait in
// a small FIFO and drain only in cycles without a scan read. With double
// buffering enabled, writes go to the back bank and a swap request flips the
// banks on the next vertical-sync falling edge once the FIFO has drained, so
// drawing never tears the displayed image.
//
// Optional feature macro: FB_DOUBLE_BUFFER_EN
//   defined   : swap state machine active, writes target the back bank.
//   undefined : single buffer, bank 0 only, swap requests ignored.
//
// Ports:
//   I_CLK, I_RST_N                   pixel clock, async active-low reset
//   I_SCAN_ADDR, I_SCAN_ACTIVE       scan controller read request
//   I_VSYNC                          vertical sync (active-low)
//   O_RED, O_GREEN, O_BLUE           pixel colour, RD_LAT+1 cycles after request
//   I_WR_VALID, O_WR_READY           GPU write handshake
//   I_WR_ADDR, I_WR_DATA             GPU write pixel address / {R,G,B}
//   I_SWAP_REQ, O_SWAP_PENDING       buffer swap request / swap outstanding
//   O_FRONT_SEL                      bank currently displayed
//   O_SRAM_ADDR, O_SRAM_WDATA        registered SRAM address / write data
//   O_SRAM_WE_N, O_SRAM_OE_N         registered active-low SRAM strobes
//   I_SRAM_RDATA                     SRAM read data, [11:0] = {R,G,B}
`default_nettype none

module frame_buffer_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LAT     = 2
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic [ADDR_W-1:0] I_SCAN_ADDR,
    input  logic              I_SCAN_ACTIVE,
    input  logic              I_VSYNC,
    output logic [3:0]        O_RED,
    output logic [3:0]        O_GREEN,
    output logic [3:0]        O_BLUE,
    input  logic              I_WR_VALID,
    output logic              O_WR_READY,
    input  logic [ADDR_W-1:0] I_WR_ADDR,
    input  logic [11:0]       I_WR_DATA,
    input  logic              I_SWAP_REQ,
    output logic              O_SWAP_PENDING,
    output logic              O_FRONT_SEL,
    output logic [ADDR_W:0]   O_SRAM_ADDR,
    output logic [15:0]       O_SRAM_WDATA,
    output logic              O_SRAM_WE_N,
    output logic              O_SRAM_OE_N,
    input  logic [15:0]       I_SRAM_RDATA
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 12;

    // Write FIFO: entries are {pixel address, colour}
    logic [ENT_W-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_ready;
    logic             w_swap_pending;
    logic             w_front_sel;
    logic             w_back_bank;
    logic [ENT_W-1:0] w_head;

    // SRAM port registers
    logic [ADDR_W:0]  r_sram_addr;
    logic [15:0]      r_sram_wdata;
    logic             r_sram_we_n;
    logic             r_sram_oe_n;

    // Read-valid tags and the final colour stage
    logic [RD_LAT-1:0] r_rd_vld_p;
    logic [11:0]       r_pixel_p;

    logic              w_unused_rdata;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = I_WR_VALID & w_wr_ready;
    // A scan read owns the SRAM cycle; the FIFO drains only in its absence.
    assign w_pop   = ~I_SCAN_ACTIVE & ~w_empty;
    assign w_head  = r_fifo_mem[r_rd_ptr];

`ifdef FB_DOUBLE_BUFFER_EN
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_t;

    swap_state_t r_swap_state;
    logic        r_front_sel;
    logic        r_vsync_d;
    logic        w_vsync_fall;

    assign w_vsync_fall = r_vsync_d & ~I_VSYNC;

    // Swap only when the FIFO is empty so no queued pixel lands in the bank
    // that has just become visible.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_swap_state <= ST_IDLE;
            r_front_sel  <= 1'b0;
            r_vsync_d    <= 1'b0;
        end else begin
            r_vsync_d <= I_VSYNC;
            case (r_swap_state)
                ST_IDLE: begin
                    if (I_SWAP_REQ) begin
                        r_swap_state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_vsync_fall && w_empty) begin
                        r_swap_state <= ST_IDLE;
                        r_front_sel  <= ~r_front_sel;
                    end
                end
                default: r_swap_state <= ST_IDLE;
            endcase
        end
    end

    assign w_swap_pending = (r_swap_state == ST_PENDING);
    assign w_front_sel    = r_front_sel;
    assign w_back_bank    = ~r_front_sel;
    // Block new writes while a swap waits so the FIFO can only drain.
    assign w_wr_ready     = ~w_full & ~w_swap_pending;
`else
    logic w_unused_swap;

    assign w_unused_swap  = I_SWAP_REQ ^ I_VSYNC;
    assign w_swap_pending = 1'b0;
    assign w_front_sel    = 1'b0;
    assign w_back_bank    = 1'b0;
    assign w_wr_ready     = ~w_full;
`endif

    // FIFO storage carries data only, so it is not reset.
    always_ff @(posedge I_CLK) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {I_WR_ADDR, I_WR_DATA};
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // SRAM cycle issue
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_we_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
        end else if (I_SCAN_ACTIVE) begin
            r_sram_addr <= {w_front_sel, I_SCAN_ADDR};
            r_sram_oe_n <= 1'b0;
            r_sram_we_n <= 1'b1;
        end else if (w_pop) begin
            r_sram_addr  <= {w_back_bank, w_head[ENT_W-1:12]};
            r_sram_wdata <= {4'h0, w_head[11:0]};
            r_sram_we_n  <= 1'b0;
            r_sram_oe_n  <= 1'b1;
        end else begin
            // Idle: strobes off, address and data hold their last values.
            r_sram_we_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
        end
    end

    // Read return: tag p0 is set on the issue edge; the last tag selects
    // whether the colour stage captures SRAM data or blanks to zero.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_rd_vld_p <= '0;
            r_pixel_p  <= '0;
        end else begin
            r_rd_vld_p <= (r_rd_vld_p << 1) | RD_LAT'(I_SCAN_ACTIVE);
            r_pixel_p  <= r_rd_vld_p[RD_LAT-1] ? I_SRAM_RDATA[11:0] : 12'h000;
        end
    end

    assign w_unused_rdata = ^I_SRAM_RDATA[15:12];

    assign O_RED          = r_pixel_p[11:8];
    assign O_GREEN        = r_pixel_p[7:4];
    assign O_BLUE         = r_pixel_p[3:0];
    assign O_WR_READY     = w_wr_ready;
    assign O_SWAP_PENDING = w_swap_pending;
    assign O_FRONT_SEL    = w_front_sel;
    assign O_SRAM_ADDR    = r_sram_addr;
    assign O_SRAM_WDATA   = r_sram_wdata;
    assign O_SRAM_WE_N    = r_sram_we_n;
    assign O_SRAM_OE_N    = r_sram_oe_n;

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter: directed stimulus with a scoreboard.
// The stimulus process pushes expected SRAM reads, colours and SRAM writes
// into queues; a monitor on the falling clock edge pops and compares them
// whenever the DUT presents a read strobe, write strobe or colour slot.
`timescale 1ns/1ps

module tb_frame_buffer_arbiter;

    localparam int ADDR_W = 20;

    logic              I_CLK = 1'b0;
    logic              I_RST_N;
    logic [ADDR_W-1:0] I_SCAN_ADDR;
    logic              I_SCAN_ACTIVE;
    logic              I_VSYNC;
    logic [3:0]        O_RED;
    logic [3:0]        O_GREEN;
    logic [3:0]        O_BLUE;
    logic              I_WR_VALID;
    logic              O_WR_READY;
    logic [ADDR_W-1:0] I_WR_ADDR;
    logic [11:0]       I_WR_DATA;
    logic              I_SWAP_REQ;
    logic              O_SWAP_PENDING;
    logic              O_FRONT_SEL;
    logic [ADDR_W:0]   O_SRAM_ADDR;
    logic [15:0]       O_SRAM_WDATA;
    logic              O_SRAM_WE_N;
    logic              O_SRAM_OE_N;
    logic [15:0]       I_SRAM_RDATA;

    frame_buffer_arbiter #(
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(8),
        .RD_LAT    (2)
    ) dut (
        .I_CLK         (I_CLK),
        .I_RST_N       (I_RST_N),
        .I_SCAN_ADDR   (I_SCAN_ADDR),
        .I_SCAN_ACTIVE (I_SCAN_ACTIVE),
        .I_VSYNC       (I_VSYNC),
        .O_RED         (O_RED),
        .O_GREEN       (O_GREEN),
        .O_BLUE        (O_BLUE),
        .I_WR_VALID    (I_WR_VALID),
        .O_WR_READY    (O_WR_READY),
        .I_WR_ADDR     (I_WR_ADDR),
        .I_WR_DATA     (I_WR_DATA),
        .I_SWAP_REQ    (I_SWAP_REQ),
        .O_SWAP_PENDING(O_SWAP_PENDING),
        .O_FRONT_SEL   (O_FRONT_SEL),
        .O_SRAM_ADDR   (O_SRAM_ADDR),
        .O_SRAM_WDATA  (O_SRAM_WDATA),
        .O_SRAM_WE_N   (O_SRAM_WE_N),
        .O_SRAM_OE_N   (O_SRAM_OE_N),
        .I_SRAM_RDATA  (I_SRAM_RDATA)
    );

    always #5 I_CLK = ~I_CLK;

    int cyc = 0;
    always @(posedge I_CLK) cyc <= cyc + 1;

    // SRAM content: address 0x000005 in bank 0 holds 0xABC; the bank bit
    // flips colour bit 11 so bank mix-ups are visible. Upper nibble is junk.
    function automatic logic [11:0] sval(input logic [ADDR_W:0] a);
        return 12'hABC ^ {a[ADDR_W], 7'b0, a[3:0] ^ 4'h5};
    endfunction

    // Two-cycle read: address registered at edge n is sampled back at n+2.
    logic [ADDR_W:0] sram_a_d1;
    always @(posedge I_CLK) sram_a_d1 <= O_SRAM_ADDR;
    assign I_SRAM_RDATA = {4'hF, sval(sram_a_d1)};

    typedef struct {
        int              due;
        logic [ADDR_W:0] addr;
        logic [11:0]     col;
    } rd_exp_t;

    typedef struct {
        logic [ADDR_W:0] addr;
        logic [15:0]     wdata;
    } wr_exp_t;

    rd_exp_t q_rd[$];
    rd_exp_t q_col[$];
    wr_exp_t q_wr[$];

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_front = 1'b0;
    logic prev_scan = 1'b0;
    logic acc;
    int   item;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic wbank();
`ifdef FB_DOUBLE_BUFFER_EN
        return ~exp_front;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [ADDR_W-1:0] wa(input int i);
        return 20'h00040 + 20'(i);
    endfunction

    function automatic logic [11:0] wd(input int i);
        logic [3:0] t;
        t = 4'(i);
        return {t, 4'hA, ~t};
    endfunction

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic scan, input logic [ADDR_W-1:0] saddr,
                        input logic wv, input logic [ADDR_W-1:0] waddr,
                        input logic [11:0] wdata, output logic accepted);
        rd_exp_t r;
        wr_exp_t w;
        I_SCAN_ACTIVE = scan;
        I_SCAN_ADDR   = saddr;
        I_WR_VALID    = wv;
        I_WR_ADDR     = waddr;
        I_WR_DATA     = wdata;
        accepted      = wv & O_WR_READY;
        if (scan) begin
            r.addr = {exp_front, saddr};
            r.col  = sval(r.addr);
            r.due  = cyc + 1;
            q_rd.push_back(r);
            r.due  = cyc + 3;
            q_col.push_back(r);
        end
        if (accepted) begin
            w.addr  = {wbank(), waddr};
            w.wdata = {4'h0, wdata};
            q_wr.push_back(w);
        end
        @(posedge I_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, '0, a);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_colour"}, 32'({O_RED, O_GREEN, O_BLUE}), 32'h0);
        chk({tag, "_sram_addr"}, 32'(O_SRAM_ADDR), 32'h0);
        chk({tag, "_sram_wdata"}, 32'(O_SRAM_WDATA), 32'h0);
        chk({tag, "_we_n"}, 32'(O_SRAM_WE_N), 32'h1);
        chk({tag, "_oe_n"}, 32'(O_SRAM_OE_N), 32'h1);
        chk({tag, "_front"}, 32'(O_FRONT_SEL), 32'h0);
        chk({tag, "_pending"}, 32'(O_SWAP_PENDING), 32'h0);
        chk({tag, "_wr_ready"}, 32'(O_WR_READY), 32'h1);
    endtask

    // Monitor / scoreboard
    always @(negedge I_CLK) begin
        rd_exp_t e;
        wr_exp_t w;
        if (I_RST_N) begin
            if (!O_SRAM_OE_N) begin
                if (q_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(O_SRAM_OE_N), 32'h1);
                end else begin
                    e = q_rd.pop_front();
                    chk("rd_addr", 32'(O_SRAM_ADDR), 32'(e.addr));
                    chk("rd_cycle", cyc, e.due);
                end
            end
            if (!O_SRAM_WE_N) begin
                if (q_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(O_SRAM_WE_N), 32'h1);
                end else begin
                    w = q_wr.pop_front();
                    chk("wr_addr", 32'(O_SRAM_ADDR), 32'(w.addr));
                    chk("wr_data", 32'(O_SRAM_WDATA), 32'(w.wdata));
                end
            end
            if (prev_scan) chk("prio_no_write", 32'(O_SRAM_WE_N), 32'h1);
            if (q_col.size() > 0 && q_col[0].due == cyc) begin
                e = q_col.pop_front();
                chk("colour", 32'({O_RED, O_GREEN, O_BLUE}), 32'(e.col));
            end else begin
                chk("colour_idle", 32'({O_RED, O_GREEN, O_BLUE}), 32'h0);
            end
        end
        prev_scan <= I_SCAN_ACTIVE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        I_RST_N       = 1'b0;
        I_SCAN_ADDR   = '0;
        I_SCAN_ACTIVE = 1'b0;
        I_VSYNC       = 1'b1;
        I_WR_VALID    = 1'b0;
        I_WR_ADDR     = '0;
        I_WR_DATA     = '0;
        I_SWAP_REQ    = 1'b0;
        repeat (3) @(posedge I_CLK);
        #1;
        check_reset_vals("reset");
        I_RST_N = 1'b1;
        idle(2);

        // Single read of 0x00005, then a short read burst.
        step(1'b1, 20'h00005, 1'b0, '0, '0, acc);
        idle(4);
        step(1'b1, 20'h00010, 1'b0, '0, '0, acc);
        step(1'b1, 20'h00011, 1'b0, '0, '0, acc);
        step(1'b1, 20'h0003F, 1'b0, '0, '0, acc);
        idle(4);

        // Fill the FIFO under continuous scan reads.
        item = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 20'h00100 + 20'(c), 1'b1, wa(item), wd(item), acc);
            if (acc) item++;
        end
        chk("fill_accepted", item, 8);
        chk("full_ready", 32'(O_WR_READY), 32'h0);
        // First drain cycle: the pop frees space but ready lags one cycle.
        step(1'b0, '0, 1'b1, wa(item), wd(item), acc);
        chk("ready_lag_acc", 32'(acc), 32'h0);
        chk("ready_after_pop", 32'(O_WR_READY), 32'h1);
        for (int c = 0; c < 20 && item < 10; c++) begin
            step(1'b0, '0, 1'b1, wa(item), wd(item), acc);
            if (acc) item++;
        end
        chk("all_accepted", item, 10);
        idle(12);
        chk("drained_ready", 32'(O_WR_READY), 32'h1);

        // Write latency from an empty FIFO, then idle hold.
        step(1'b0, '0, 1'b1, 20'h00777, 12'h3C5, acc);
        step(1'b0, '0, 1'b0, '0, '0, acc);
        chk("wr_lat_we_n", 32'(O_SRAM_WE_N), 32'h0);
        chk("wr_lat_addr", 32'(O_SRAM_ADDR), 32'({wbank(), 20'h00777}));
        step(1'b0, '0, 1'b0, '0, '0, acc);
        chk("wr_one_cycle", 32'(O_SRAM_WE_N), 32'h1);
        chk("idle_addr_hold", 32'(O_SRAM_ADDR), 32'({wbank(), 20'h00777}));
        chk("idle_wdata_hold", 32'(O_SRAM_WDATA), 32'h3C5);

        // Three queued writes against alternating scan reads.
        for (int i = 0; i < 3; i++) step(1'b1, 20'h00180 + 20'(i), 1'b1, wa(20 + i), wd(20 + i), acc);
        for (int c = 0; c < 8; c++) step((c % 2) == 0, 20'h00200 + 20'(c), 1'b0, '0, '0, acc);
        idle(4);

        // Reset with five queued writes and reads in flight.
        for (int i = 0; i < 5; i++) step(1'b1, 20'h00300 + 20'(i), 1'b1, wa(30 + i), wd(30 + i), acc);
        I_SCAN_ACTIVE = 1'b0;
        I_WR_VALID    = 1'b0;
        #1;
        I_RST_N = 1'b0;
        q_rd.delete();
        q_col.delete();
        q_wr.delete();
        exp_front = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        #1;
        I_RST_N = 1'b1;
        @(posedge I_CLK);
        #1;
        idle(8);
        chk("post_reset_we_n", 32'(O_SRAM_WE_N), 32'h1);
        chk("post_reset_ready", 32'(O_WR_READY), 32'h1);

`ifdef FB_DOUBLE_BUFFER_EN
        // Swap with queued writes: blocked writes, no swap while non-empty.
        step(1'b1, 20'h00400, 1'b1, wa(40), wd(40), acc);
        step(1'b1, 20'h00401, 1'b1, wa(41), wd(41), acc);
        I_SWAP_REQ = 1'b1;
        step(1'b1, 20'h00402, 1'b0, '0, '0, acc);
        I_SWAP_REQ = 1'b0;
        chk("swap_pending", 32'(O_SWAP_PENDING), 32'h1);
        chk("swap_ready_low", 32'(O_WR_READY), 32'h0);
        step(1'b1, 20'h00403, 1'b1, wa(42), wd(42), acc);
        chk("swap_wr_blocked", 32'(acc), 32'h0);
        I_VSYNC = 1'b0;
        step(1'b1, 20'h00404, 1'b0, '0, '0, acc);
        I_VSYNC = 1'b1;
        step(1'b1, 20'h00405, 1'b0, '0, '0, acc);
        chk("no_swap_front", 32'(O_FRONT_SEL), 32'h0);
        chk("no_swap_pending", 32'(O_SWAP_PENDING), 32'h1);
        idle(3);
        I_VSYNC = 1'b0;
        step(1'b0, '0, 1'b0, '0, '0, acc);
        I_VSYNC = 1'b1;
        chk("swap_front", 32'(O_FRONT_SEL), 32'h1);
        chk("swap_done", 32'(O_SWAP_PENDING), 32'h0);
        chk("swap_ready", 32'(O_WR_READY), 32'h1);
        exp_front = 1'b1;
        step(1'b1, 20'h00007, 1'b1, wa(43), wd(43), acc);
        idle(5);
`else
        // Single-buffer build: swaps ignored, writes to bank 0.
        I_SWAP_REQ = 1'b1;
        step(1'b0, '0, 1'b0, '0, '0, acc);
        I_SWAP_REQ = 1'b0;
        chk("nodb_pending", 32'(O_SWAP_PENDING), 32'h0);
        chk("nodb_ready", 32'(O_WR_READY), 32'h1);
        I_VSYNC = 1'b0;
        step(1'b1, 20'h00009, 1'b1, 20'hABCDE, 12'h5A5, acc);
        I_VSYNC = 1'b1;
        chk("nodb_acc", 32'(acc), 32'h1);
        chk("nodb_front", 32'(O_FRONT_SEL), 32'h0);
        idle(5);
        chk("nodb_front_late", 32'(O_FRONT_SEL), 32'h0);
`endif

        chk("q_rd_drained", q_rd.size(), 0);
        chk("q_col_drained", q_col.size(), 0);
        chk("q_wr_drained", q_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
